// File: rtl/axi_read_master.sv
// axi_read_master: AXI4 read-burst master with a local command port and a
// buffered valid/ready output stream.
//
// Ports:
//   aclk, aresetn           clock, synchronous active-low reset
//   cmd_*                   client command: start byte address, AXI length
//   ar*                     AXI read address channel (one INCR burst per command)
//   r*                      AXI read data channel
//   out_*                   FWFT stream of returned beats, out_last on the final beat
//   done, err_resp, err_last  burst completion pulse and its error flags
//   err_len                 pulse when a command is longer than the beat buffer
//
// state      | meaning
// IDLE       | ready for a command
// WAIT_SPACE | command latched, waiting for FIFO room for the whole burst
// ADDR       | presenting the burst on the AR channel
// DATA       | collecting beats until the counted final beat
module axi_read_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int STROBE_WIDTH  = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [7:0]               cmd_len,
  output logic [ADDRESS_WIDTH-1:0] araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done,
  output logic                     err_resp,
  output logic                     err_last,
  output logic                     err_len
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0] SIZE = 3'($clog2(STROBE_WIDTH));
  localparam logic [9:0] DEPTH_W = 10'(FIFO_DEPTH);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_SPACE = 2'd1;
  localparam logic [1:0] ADDR       = 2'd2;
  localparam logic [1:0] DATA       = 2'd3;

  logic [1:0]            state;
  logic [7:0]            len_q;
  logic [8:0]            beat_cnt;
  logic                  acc_resp;
  logic                  acc_last;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic       full;
  logic       push;
  logic       pop;
  logic       is_final;
  logic       beat_resp_err;
  logic       beat_last_err;
  logic [9:0] free_space;
  logic [9:0] need;
  logic [9:0] cmd_need;

  assign full          = (count == CNT_W'(FIFO_DEPTH));
  assign cmd_ready     = (state == IDLE);
  assign rready        = (state == DATA) && !full;
  assign out_valid     = (count != '0);
  assign out_data      = mem_data[rd_ptr];
  assign out_last      = mem_last[rd_ptr];
  assign arsize        = SIZE;
  assign arburst       = 2'b01;

  assign push          = rvalid && rready;
  assign pop           = out_valid && out_ready;
  // The final beat is the one we counted to, independent of what rlast says.
  assign is_final      = (beat_cnt == {1'b0, len_q});
  assign beat_resp_err = (rresp != 2'b00);
  assign beat_last_err = (rlast != is_final);

  // 10-bit arithmetic so cmd_len+1 = 256 and FIFO_DEPTH = 256 both fit.
  assign free_space    = DEPTH_W - 10'(count);
  assign need          = 10'(len_q) + 10'd1;
  assign cmd_need      = 10'(cmd_len) + 10'd1;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= IDLE;
      len_q    <= '0;
      beat_cnt <= '0;
      acc_resp <= 1'b0;
      acc_last <= 1'b0;
      araddr   <= '0;
      arlen    <= '0;
      arvalid  <= 1'b0;
      done     <= 1'b0;
      err_resp <= 1'b0;
      err_last <= 1'b0;
      err_len  <= 1'b0;
    end else begin
      done     <= 1'b0;
      err_resp <= 1'b0;
      err_last <= 1'b0;
      err_len  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_need > DEPTH_W) begin
              err_len <= 1'b1;
            end else begin
              len_q  <= cmd_len;
              araddr <= cmd_addr;
              arlen  <= cmd_len;
              state  <= WAIT_SPACE;
            end
          end
        end
        WAIT_SPACE: begin
          // Only pops happen here, so once room appears it cannot vanish.
          if (free_space >= need) begin
            arvalid <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid  <= 1'b0;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        default: begin
          if (push) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (is_final) begin
              done     <= 1'b1;
              err_resp <= acc_resp | beat_resp_err;
              err_last <= acc_last | beat_last_err;
              acc_resp <= 1'b0;
              acc_last <= 1'b0;
              state    <= IDLE;
            end else begin
              acc_resp <= acc_resp | beat_resp_err;
              acc_last <= acc_last | beat_last_err;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_data[wr_ptr] <= rdata;
      mem_last[wr_ptr] <= is_final;
    end
  end

endmodule

// File: tb/tb_axi_read_master.sv
// tb_axi_read_master: directed bench for axi_read_master. The bench plays the
// AXI slave and the stream sink, records every handshake, and compares
// against hand-computed expectations.
module tb_axi_read_master;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic [7:0]  araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        done;
  logic        err_resp;
  logic        err_last;
  logic        err_len;

  always #5 aclk = ~aclk;

  axi_read_master #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(8), .FIFO_DEPTH(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .err_resp(err_resp), .err_last(err_last), .err_len(err_len)
  );

  int          n_pass = 0;
  int          n_total = 0;
  int          done_cnt = 0;
  int          errlen_cnt = 0;
  logic        last_err_resp = 1'b0;
  logic        last_err_last = 1'b0;
  bit          arv_seen = 1'b0;
  bit          tog = 1'b0;
  logic [32:0] got_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: record handshakes that the coming edge will take, then wait
  // for the edge and sample registered outputs on the following negedge.
  task automatic cyc();
    if (tog) out_ready = ~out_ready;
    if (out_valid === 1'b1 && out_ready) got_q.push_back({out_last, out_data});
    @(posedge aclk);
    @(negedge aclk);
    if (done === 1'b1) begin
      done_cnt++;
      last_err_resp = err_resp;
      last_err_last = err_last;
    end
    if (err_len === 1'b1) errlen_cnt++;
    if (arvalid === 1'b1) arv_seen = 1'b1;
  endtask

  task automatic do_cmd(input logic [7:0] addr, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    for (int k = 0; k < 100 && cmd_ready !== 1'b1; k++) cyc();
    if (cmd_ready !== 1'b1) check("cmd_ready_timeout", {63'd0, cmd_ready}, 64'd1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic addr_phase(input logic [7:0] addr, input logic [7:0] len, output int waited);
    waited = 0;
    while (arvalid !== 1'b1 && waited < 100) begin
      cyc();
      waited++;
    end
    check("arvalid", {63'd0, arvalid}, 64'd1);
    check("araddr", {56'd0, araddr}, {56'd0, addr});
    check("arlen", {56'd0, arlen}, {56'd0, len});
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    check("arvalid_drop", {63'd0, arvalid}, 64'd0);
  endtask

  // Drives beats 0..len; stops before beat stop_at (for the reset case).
  task automatic send_beats(input int len, input logic [31:0] base, input bit gaps,
                            input int resp_beat, input int last_beat, input int stop_at);
    for (int i = 0; i <= len; i++) begin
      if (i == stop_at) break;
      if (gaps && (i % 2 == 1)) begin
        rvalid = 1'b0;
        cyc();
      end
      rvalid = 1'b1;
      rdata  = base + 32'(i);
      rresp  = (i == resp_beat) ? 2'b10 : 2'b00;
      rlast  = (i == len) || (i == last_beat);
      for (int k = 0; k < 100 && rready !== 1'b1; k++) cyc();
      if (rready !== 1'b1) check("rready_timeout", {63'd0, rready}, 64'd1);
      cyc();
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
    end
  endtask

  task automatic check_stream(input string tag, input int start, input int len, input logic [31:0] base);
    for (int i = 0; i <= len; i++) begin
      if (start + i < got_q.size())
        check(tag, {31'd0, got_q[start + i]}, {31'd0, (i == len), base + 32'(i)});
      else
        check({tag, "_missing"}, 64'(got_q.size()), 64'(start + i + 1));
    end
  endtask

  task automatic drain(input int cycles);
    tog = 1'b0;
    out_ready = 1'b1;
    repeat (cycles) cyc();
  endtask

  int waited;
  int d0;

  initial begin
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    check("rst_arvalid", {63'd0, arvalid}, 64'd0);
    check("rst_rready", {63'd0, rready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_done", {61'd0, done, err_resp, err_last}, 64'd0);
    check("rst_araddr_arlen", {48'd0, araddr, arlen}, 64'd0);
    aresetn = 1'b1;
    cyc();
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // single beat
    got_q.delete();
    d0 = done_cnt;
    do_cmd(8'h10, 8'd0);
    addr_phase(8'h10, 8'd0, waited);
    check("t1_latency", 64'(waited), 64'd1);
    check("t1_arsize", {61'd0, arsize}, 64'd2);
    check("t1_arburst", {62'd0, arburst}, 64'd1);
    send_beats(0, 32'hDEADBEEF, 1'b0, -1, -1, -1);
    check("t1_done", 64'(done_cnt), 64'(d0 + 1));
    check("t1_errs", {62'd0, last_err_resp, last_err_last}, 64'd0);
    drain(3);
    check("t1_count", 64'(got_q.size()), 64'd1);
    check_stream("t1_beat", 0, 0, 32'hDEADBEEF);
    check("t1_done_once", 64'(done_cnt), 64'(d0 + 1));

    // gaps on R, toggling out_ready
    got_q.delete();
    d0 = done_cnt;
    do_cmd(8'h20, 8'd3);
    addr_phase(8'h20, 8'd3, waited);
    tog = 1'b1;
    send_beats(3, 32'h1000_0000, 1'b1, -1, -1, -1);
    check("t2_done", 64'(done_cnt), 64'(d0 + 1));
    drain(8);
    check("t2_count", 64'(got_q.size()), 64'd4);
    check_stream("t2_beat", 0, 3, 32'h1000_0000);

    // over-long command
    arv_seen = 1'b0;
    d0 = errlen_cnt;
    do_cmd(8'h40, 8'd16);
    check("t3_err_len", 64'(errlen_cnt), 64'(d0 + 1));
    repeat (4) cyc();
    check("t3_err_len_once", 64'(errlen_cnt), 64'(d0 + 1));
    check("t3_no_arvalid", {63'd0, arv_seen}, 64'd0);
    check("t3_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // back-pressure: wait for room
    got_q.delete();
    out_ready = 1'b0;
    do_cmd(8'h00, 8'd11);
    addr_phase(8'h00, 8'd11, waited);
    send_beats(11, 32'hA000_0000, 1'b0, -1, -1, -1);
    arv_seen = 1'b0;
    do_cmd(8'h80, 8'd7);
    repeat (5) cyc();
    check("t4_wait_full", {63'd0, arv_seen}, 64'd0);
    out_ready = 1'b1;
    repeat (3) cyc();
    out_ready = 1'b0;
    repeat (4) cyc();
    check("t4_wait_free7", {63'd0, arv_seen}, 64'd0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("t4_arvalid_pre", {63'd0, arvalid}, 64'd0);
    cyc();
    check("t4_arvalid_free8", {63'd0, arvalid}, 64'd1);
    addr_phase(8'h80, 8'd7, waited);
    d0 = done_cnt;
    send_beats(7, 32'hB000_0000, 1'b0, -1, -1, -1);
    check("t4_done", 64'(done_cnt), 64'(d0 + 1));
    drain(20);
    check("t4_count", 64'(got_q.size()), 64'd20);
    check_stream("t4_a", 0, 11, 32'hA000_0000);
    check_stream("t4_b", 12, 7, 32'hB000_0000);

    // error accumulation, then a clean burst
    got_q.delete();
    d0 = done_cnt;
    do_cmd(8'h30, 8'd3);
    addr_phase(8'h30, 8'd3, waited);
    send_beats(3, 32'hC000_0000, 1'b0, 1, 2, -1);
    check("t5_done", 64'(done_cnt), 64'(d0 + 1));
    check("t5_errs", {62'd0, last_err_resp, last_err_last}, 64'd3);
    do_cmd(8'h34, 8'd1);
    addr_phase(8'h34, 8'd1, waited);
    send_beats(1, 32'hC100_0000, 1'b0, -1, -1, -1);
    check("t5_clean_done", 64'(done_cnt), 64'(d0 + 2));
    check("t5_clean_errs", {62'd0, last_err_resp, last_err_last}, 64'd0);
    drain(8);
    check("t5_count", 64'(got_q.size()), 64'd6);

    // reset mid-burst
    got_q.delete();
    out_ready = 1'b0;
    do_cmd(8'h50, 8'd3);
    addr_phase(8'h50, 8'd3, waited);
    send_beats(3, 32'hD000_0000, 1'b0, -1, -1, 2);
    check("t6_buffered", {63'd0, out_valid}, 64'd1);
    d0 = done_cnt;
    aresetn = 1'b0;
    cyc();
    aresetn = 1'b1;
    check("t6_out_valid", {63'd0, out_valid}, 64'd0);
    check("t6_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("t6_rready", {63'd0, rready}, 64'd0);
    out_ready = 1'b1;
    repeat (5) cyc();
    check("t6_no_done", 64'(done_cnt), 64'(d0));
    check("t6_empty", 64'(got_q.size()), 64'd0);

    // recovery after reset
    do_cmd(8'h60, 8'd0);
    addr_phase(8'h60, 8'd0, waited);
    send_beats(0, 32'hE000_0000, 1'b0, -1, -1, -1);
    check("t6_recover_done", 64'(done_cnt), 64'(d0 + 1));
    drain(3);
    check_stream("t6_recover_beat", 0, 0, 32'hE000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_read_master.md
Name: axi_read_master

Overview:
- AXI4 read-burst master that drives the read address and read data channels of the on-chip AXI slave RAM.
- Accepts simple commands (start address, beat count) from a local client and issues one INCR burst per command.
- Buffers returned beats in an internal FIFO and presents them as a valid/ready stream with a last-beat marker.
- Issues a burst only when the FIFO has room for every beat, so rready never stalls mid-burst under normal operation.

Parameters:
DATA_WIDTH, 32, data bus width in bits
ADDRESS_WIDTH, 8, byte address width
STROBE_WIDTH, DATA_WIDTH/8, bytes per beat; arsize = log2(STROBE_WIDTH)
FIFO_DEPTH, 16, beat buffer entries; power of 2, max 256

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_addr  in  ADDRESS_WIDTH  burst start byte address (word aligned)
cmd_len  in  8  AXI length; beats = cmd_len+1
araddr  out  ADDRESS_WIDTH  read address
arlen  out  8  burst length
arsize  out  3  constant log2(STROBE_WIDTH)
arburst  out  2  constant 2'b01 (INCR)
arvalid  out  1  address valid
arready  in  1  address ready
rdata  in  DATA_WIDTH  read data
rresp  in  2  read response
rlast  in  1  last beat of burst
rvalid  in  1  read data valid
rready  out  1  read data ready
out_data  out  DATA_WIDTH  stream data
out_last  out  1  final beat of a command
out_valid  out  1  stream valid
out_ready  in  1  stream ready
done  out  1  one-cycle pulse when a burst completes on R channel
err_resp  out  1  valid with done: some beat had rresp != 2'b00
err_last  out  1  valid with done: rlast mismatched the beat count
err_len  out  1  one-cycle pulse: command rejected, cmd_len+1 > FIFO_DEPTH

Behaviour:
- Reset (aresetn low at posedge):
  - state=IDLE; FIFO emptied.
  - arvalid, rready, out_valid, done, err_* = 0; araddr, arlen = 0.
  - Reset mid-burst abandons the burst; no done is produced.
- States: IDLE, WAIT_SPACE, ADDR, DATA.
- IDLE:
  - cmd_ready=1; cmd_ready is 0 in every other state.
  - On accept with cmd_len+1 > FIFO_DEPTH: err_len pulses next cycle; stay IDLE.
  - Otherwise latch addr/len and go to WAIT_SPACE.
- WAIT_SPACE:
  - Go to ADDR when free entries (FIFO_DEPTH - count) >= len+1.
  - Free space only grows here.
  - A burst never starts with insufficient space reserved.
- ADDR:
  - arvalid=1 with araddr/arlen registered.
  - arvalid and its payload stay stable until arready.
  - On arvalid && arready go to DATA; arvalid drops the next cycle.
  - arvalid never depends combinationally on arready.
- DATA:
  - rready=1 whenever the FIFO is not full.
  - Each rvalid && rready pushes {rdata, is_final}, where is_final = (beat counter == len).
  - Beat counter is 9 bits, starts at 0.
  - rresp != 0 on any beat sets the err_resp accumulator.
  - rlast on a beat where is_final=0, or !rlast on the final beat, sets the err_last accumulator.
  - On the final beat (counted, not rlast): go to IDLE; next cycle done=1 with err_resp/err_last = accumulators; accumulators clear.
- Beats after the counted final beat are not accepted (rready=0 in IDLE).
- FIFO:
  - First-word-fall-through; out_valid = !empty; out_data/out_last from head.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop in one cycle leaves count unchanged; push when full is impossible by construction.
  - count width = log2(FIFO_DEPTH)+1.
- Latency:
  - cmd accept to arvalid: 2 cycles minimum (WAIT_SPACE passes immediately when space is free).
  - R beat pushed at cycle N appears at out_valid at N+1.
- A new command may be accepted while earlier data still drains from the FIFO.

Test Plan:
- cmd_addr=0x10, cmd_len=0, out_ready=1:
  - araddr=0x10, arlen=0, arsize=2, arburst=1.
  - One beat 0xDEADBEEF out with out_last=1.
  - done=1, err_resp=0, err_last=0.
- cmd_addr=0x20, cmd_len=3, slave inserts rvalid gaps, out_ready toggles 1/0:
  - 4 beats out in order; out_last only on the 4th.
  - done one cycle after 4th R handshake; no beat lost or duplicated.
- FIFO_DEPTH=16, cmd_len=16:
  - err_len pulses; arvalid never asserts; cmd_ready returns 1.
- out_ready=0; cmd len=11 completes (12 entries); second cmd len=7:
  - arvalid stays 0 in WAIT_SPACE.
  - After 3 pops (free=7) still waits; 4th pop (free=8) leads to arvalid.
- cmd_len=3 with rresp=2'b10 on beat 1 and rlast asserted on beat 2:
  - done with err_resp=1, err_last=1.
  - Next clean burst reports both 0.
- aresetn low for 1 cycle after 2 of 4 beats received:
  - FIFO empty, out_valid=0, no done.
  - cmd_ready=1 the cycle after reset releases.
